mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  Memory-side stage of the multi-cycle CPU, directly upstream of the controller.
//  Turns the controller's MemRead/MemWrite/IorD/IRWrite strobes into a req/ready transaction to a
//  variable-latency unified memory, and captures fetched data into the instruction register
//  (IR -> OpCode/Funct to the controller) and the memory data register (MDR -> lw writeback).
//  Drives Stall so the controller holds its state until the access completes.
// PARAMETERS
//  DATA_W   32  data/instruction width
//  ADDR_W   32  byte address width
//  TIMEOUT  15  max WAIT cycles without mem_ready before abort (1..255)
// PORTS
//  clk        in   1       system clock, rising edge
//  reset      in   1       synchronous, active-high
//  MemRead    in   1       controller read strobe
//  MemWrite   in   1       controller write strobe
//  IRWrite    in   1       load IR with read data on completion
//  IorD       in   1       address select: 0 = PC, 1 = ALUOut
//  PC         in   ADDR_W  fetch address
//  ALUOut     in   ADDR_W  data address
//  WriteData  in   DATA_W  store data (rt)
//  mem_req    out  1       request valid, held until mem_ready
//  mem_we     out  1       1 = write
//  mem_addr   out  ADDR_W  request address
//  mem_wdata  out  DATA_W  write data
//  mem_rdata  in   DATA_W  read data, valid when mem_ready
//  mem_ready  in   1       completion, single-cycle pulse
//  Instruction out DATA_W  IR contents
//  OpCode     out  6       IR[31:26]
//  Funct      out  6       IR[5:0]
//  MDR        out  DATA_W  memory data register
//  Stall      out  1       controller must hold state while high
//  Error      out  1       sticky fault flag
// BEHAVIOUR
//  - Reset (sync): state IDLE; mem_req/mem_we 0; mem_addr/mem_wdata/Instruction/MDR 0; Error 0.
//  - FSM IDLE -> WAIT -> IDLE.
//  - IDLE: when MemRead|MemWrite, latch addr = IorD ? ALUOut : PC, latch we and wdata,
//    IRWrite, and mem_req=1 from the next edge; go to WAIT with the timer cleared.
//    Stall = MemRead|MemWrite (combinational).
//  - WAIT: mem_req held with stable addr/we/wdata. Stall = ~mem_ready.
//    On mem_ready: read -> MDR <= mem_rdata; if latched IRWrite, Instruction <= mem_rdata.
//    Write -> no capture. mem_req drops at that edge; state returns to IDLE.
//  - Latency: min 2 cycles (request cycle + ready cycle); controller advances on the ready edge.
//  - Back-to-back: a new strobe in the cycle after completion starts a new request immediately.
//  - MemRead & MemWrite both high: treated as a write; Error set.
//  - mem_addr[1:0] != 0 at request: access still issued; Error set.
//  - Timeout: TIMEOUT consecutive WAIT cycles without mem_ready -> abort. mem_req drops, Error set,
//    IR/MDR unchanged, Stall low for one cycle, state IDLE. A late mem_ready in IDLE is ignored.
//  - mem_ready while IDLE: ignored; no capture.
//  - Error is sticky and clears only on reset.
//  - Reset mid-WAIT: mem_req drops at the reset edge; no capture.
//  - OpCode/Funct are pure slices of Instruction; stable except on an IR capture edge.
// CONFIGURATION
//  MEM_PERF_CNT_EN defined:
//    - adds out ports access_count[31:0] (+1 per completed access) and
//      wait_cycles[31:0] (+1 per WAIT cycle with mem_ready low);
//    - both reset to 0 and wrap at 2^32; timeouts do not count as accesses.
//  Undefined: ports and counters absent; all other behaviour identical.
// TESTING
//  - Fetch: PC=0x0000_0040, IorD=0, MemRead=IRWrite=1, ready after 3 cycles with rdata 0x0109_4020
//    -> mem_addr 0x40, Stall high 3 cycles, OpCode 0x00, Funct 0x20, MDR 0x0109_4020.
//  - lw: IorD=1, ALUOut=0x100, IRWrite=0, rdata 0xDEAD_BEEF in 1 cycle
//    -> MDR 0xDEAD_BEEF, Instruction unchanged.
//  - sw: MemWrite=1, ALUOut=0x104, WriteData=0x1234_5678 -> mem_we=1, wdata held until ready;
//    MDR unchanged.
//  - Timeout: no mem_ready for 15 cycles -> mem_req drops at cycle 15, Error=1, IR/MDR unchanged;
//    later ready ignored.
//  - Reset mid-WAIT -> next edge mem_req=0, all outputs 0; misaligned ALUOut=0x102 -> Error=1.
//  - MEM_PERF_CNT_EN: 3 accesses with 2, 0, 4 wait cycles -> access_count 3, wait_cycles 6.

Source files
------------

// File: rtl/mem_access_unit.sv
// mem_access_unit
//   Memory-side stage of the multi-cycle CPU. Converts the controller's
//   MemRead/MemWrite/IorD/IRWrite strobes into a single req/ready transaction
//   to a variable-latency unified memory, and captures the returned word into
//   the instruction register (IR) and/or the memory data register (MDR).
//   Stall holds the controller until the access completes or is aborted.
//
// Optional build: define MEM_PERF_CNT_EN to add the access_count and
//   wait_cycles performance counters (and their output ports).
//
// Ports
//   clk, reset               rising-edge clock, synchronous active-high reset
//   MemRead, MemWrite        controller access strobes
//   IRWrite                  load IR with the read data on completion
//   IorD                     address select: 0 = PC, 1 = ALUOut
//   PC, ALUOut, WriteData    address sources and store data
//   mem_req/we/addr/wdata    request to memory, held stable until mem_ready
//   mem_rdata, mem_ready     response; mem_ready is a single-cycle pulse
//   Instruction/OpCode/Funct IR contents and its opcode/funct fields
//   MDR                      memory data register (load writeback)
//   Stall                    controller holds state while high
//   Error                    sticky fault flag (conflict, misalign, timeout)
//   access_count/wait_cycles performance counters (MEM_PERF_CNT_EN only)
module mem_access_unit #(
    parameter int DATA_W  = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MemRead,
    input  logic              MemWrite,
    input  logic              IRWrite,
    input  logic              IorD,
    input  logic [ADDR_W-1:0] PC,
    input  logic [ADDR_W-1:0] ALUOut,
    input  logic [DATA_W-1:0] WriteData,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [DATA_W-1:0] Instruction,
    output logic [5:0]        OpCode,
    output logic [5:0]        Funct,
    output logic [DATA_W-1:0] MDR,
    output logic              Stall,
    output logic              Error
`ifdef MEM_PERF_CNT_EN
    ,
    output logic [31:0]       access_count,
    output logic [31:0]       wait_cycles
`endif
);

    typedef enum logic {
        S_IDLE = 1'b0,
        S_WAIT = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;
    logic              irw_q, irw_d;
    logic [DATA_W-1:0] instr_q, instr_d;
    logic [DATA_W-1:0] mdr_q, mdr_d;
    logic              err_q, err_d;
    logic [7:0]        timer_q, timer_d;
    // One-cycle marker following a timeout abort: Stall is forced low so the
    // controller can move on, and no new request is accepted in that cycle.
    logic              abort_q, abort_d;
`ifdef MEM_PERF_CNT_EN
    logic [31:0]       acc_cnt_q, acc_cnt_d;
    logic [31:0]       wait_cnt_q, wait_cnt_d;
`endif

    logic              strobe;
    logic [ADDR_W-1:0] req_addr;

    assign strobe   = MemRead | MemWrite;
    assign req_addr = IorD ? ALUOut : PC;

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        irw_d   = irw_q;
        instr_d = instr_q;
        mdr_d   = mdr_q;
        err_d   = err_q;
        timer_d = timer_q;
        abort_d = 1'b0;
        Stall   = 1'b0;
`ifdef MEM_PERF_CNT_EN
        acc_cnt_d  = acc_cnt_q;
        wait_cnt_d = wait_cnt_q;
`endif
        case (state_q)
            S_IDLE: begin
                // mem_ready arriving here (late or spurious) is ignored.
                Stall = strobe & ~abort_q;
                if (strobe && !abort_q) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    // A simultaneous read+write resolves to a write.
                    we_d    = MemWrite;
                    addr_d  = req_addr;
                    wdata_d = WriteData;
                    irw_d   = IRWrite;
                    timer_d = 8'd0;
                    if ((MemRead && MemWrite) || (req_addr[1:0] != 2'b00))
                        err_d = 1'b1;
                end
            end
            S_WAIT: begin
                Stall = ~mem_ready;
                if (mem_ready) begin
                    state_d = S_IDLE;
                    req_d   = 1'b0;
                    we_d    = 1'b0;
                    if (!we_q) begin
                        mdr_d = mem_rdata;
                        if (irw_q)
                            instr_d = mem_rdata;
                    end
`ifdef MEM_PERF_CNT_EN
                    acc_cnt_d = acc_cnt_q + 32'd1;
`endif
                end else begin
`ifdef MEM_PERF_CNT_EN
                    wait_cnt_d = wait_cnt_q + 32'd1;
`endif
                    if (timer_q == 8'(TIMEOUT - 1)) begin
                        // Abort: drop the request, leave IR/MDR untouched.
                        state_d = S_IDLE;
                        req_d   = 1'b0;
                        we_d    = 1'b0;
                        err_d   = 1'b1;
                        abort_d = 1'b1;
                    end else begin
                        timer_d = timer_q + 8'd1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                req_d   = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            irw_q   <= 1'b0;
            instr_q <= '0;
            mdr_q   <= '0;
            err_q   <= 1'b0;
            timer_q <= 8'd0;
            abort_q <= 1'b0;
`ifdef MEM_PERF_CNT_EN
            acc_cnt_q  <= 32'd0;
            wait_cnt_q <= 32'd0;
`endif
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            irw_q   <= irw_d;
            instr_q <= instr_d;
            mdr_q   <= mdr_d;
            err_q   <= err_d;
            timer_q <= timer_d;
            abort_q <= abort_d;
`ifdef MEM_PERF_CNT_EN
            acc_cnt_q  <= acc_cnt_d;
            wait_cnt_q <= wait_cnt_d;
`endif
        end
    end

    assign mem_req     = req_q;
    assign mem_we      = we_q;
    assign mem_addr    = addr_q;
    assign mem_wdata   = wdata_q;
    assign Instruction = instr_q;
    assign OpCode      = instr_q[31:26];
    assign Funct       = instr_q[5:0];
    assign MDR         = mdr_q;
    assign Error       = err_q;
`ifdef MEM_PERF_CNT_EN
    assign access_count = acc_cnt_q;
    assign wait_cycles  = wait_cnt_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. Inputs change and outputs are
// sampled on the falling clock edge. Each access pushes its expected request
// onto a scoreboard queue; the entry is compared against the DUT request
// while it waits and popped when the response has been captured.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        MemRead = 0, MemWrite = 0, IRWrite = 0, IorD = 0;
    logic [31:0] PC = '0, ALUOut = '0, WriteData = '0;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [31:0] mem_rdata = '0;
    logic        mem_ready = 1'b0;
    logic [31:0] Instruction, MDR;
    logic [5:0]  OpCode, Funct;
    logic        Stall, Error;
`ifdef MEM_PERF_CNT_EN
    logic [31:0] access_count, wait_cycles;
`endif

    mem_access_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(15)) dut (
        .clk(clk), .reset(reset),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .IorD(IorD),
        .PC(PC), .ALUOut(ALUOut), .WriteData(WriteData),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready),
        .Instruction(Instruction), .OpCode(OpCode), .Funct(Funct), .MDR(MDR),
        .Stall(Stall), .Error(Error)
`ifdef MEM_PERF_CNT_EN
        , .access_count(access_count), .wait_cycles(wait_cycles)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        irw;
    } sb_t;

    sb_t sb_q[$];

    int n_chk = 0;
    int n_err = 0;
    logic [31:0] exp_ir = '0, exp_mdr = '0;
    logic        exp_err = 1'b0;
    int          exp_acc = 0, exp_wait = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        exp_ir = '0; exp_mdr = '0; exp_err = 1'b0; exp_acc = 0; exp_wait = 0;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_req"},   mem_req,     0);
        chk({tag, "_we"},    mem_we,      0);
        chk({tag, "_addr"},  mem_addr,    0);
        chk({tag, "_wdata"}, mem_wdata,   0);
        chk({tag, "_ir"},    Instruction, 0);
        chk({tag, "_mdr"},   MDR,         0);
        chk({tag, "_err"},   Error,       0);
        chk({tag, "_stall"}, Stall,       0);
    endtask

    // Called and returns on a falling edge, so consecutive calls issue
    // back-to-back requests in the cycle after completion.
    task automatic do_access(input logic rd, input logic wr, input logic irw,
                             input logic iord, input logic [31:0] pc,
                             input logic [31:0] alu, input logic [31:0] wd,
                             input int lat, input logic [31:0] rdata);
        sb_t e;
        e.addr = iord ? alu : pc;
        e.we = wr; e.wdata = wd; e.rdata = rdata; e.irw = irw;
        sb_q.push_back(e);
        MemRead = rd; MemWrite = wr; IRWrite = irw; IorD = iord;
        PC = pc; ALUOut = alu; WriteData = wd;
        #1 chk("stall_req_cycle", Stall, 1);
        @(posedge clk); @(negedge clk);
        e = sb_q[0];
        for (int i = 0; i < lat; i++) begin
            chk("wait_req", mem_req, 1);
            chk("wait_addr", mem_addr, e.addr);
            chk("wait_we", mem_we, e.we);
            if (e.we) chk("wait_wdata", mem_wdata, e.wdata);
            chk("wait_stall", Stall, 1);
            @(posedge clk); @(negedge clk);
        end
        mem_ready = 1'b1; mem_rdata = e.rdata;
        #1;
        chk("ready_req", mem_req, 1);
        chk("ready_addr", mem_addr, e.addr);
        chk("ready_we", mem_we, e.we);
        chk("ready_stall", Stall, 0);
        @(posedge clk); @(negedge clk);
        mem_ready = 1'b0; MemRead = 0; MemWrite = 0; IRWrite = 0;
        e = sb_q.pop_front();
        if (!e.we) begin
            exp_mdr = e.rdata;
            if (e.irw) exp_ir = e.rdata;
        end
        if ((rd && wr) || e.addr[1:0] != 2'b00) exp_err = 1'b1;
        exp_acc++; exp_wait += lat;
        chk("done_req", mem_req, 0);
        chk("done_mdr", MDR, exp_mdr);
        chk("done_ir", Instruction, exp_ir);
        chk("done_opcode", OpCode, exp_ir[31:26]);
        chk("done_funct", Funct, exp_ir[5:0]);
        chk("done_err", Error, exp_err);
    endtask

    initial begin
        @(negedge clk);
        do_reset();
        check_idle_outputs("rst");

        // Fetch: R-type add, 2 wait cycles -> Stall high for 3 cycles
        do_access(1, 0, 1, 0, 32'h40, 32'h0, 32'h0, 2, 32'h0109_4020);
        chk("fetch_opcode", OpCode, 6'h00);
        chk("fetch_funct", Funct, 6'h20);
        chk("fetch_mdr", MDR, 32'h0109_4020);
        // lw, ready immediately, IR untouched
        do_access(1, 0, 0, 1, 32'h44, 32'h100, 32'h0, 0, 32'hDEAD_BEEF);
        chk("lw_ir_kept", Instruction, 32'h0109_4020);
        // sw: no capture
        do_access(0, 1, 0, 1, 32'h48, 32'h104, 32'h1234_5678, 1, 32'hFFFF_FFFF);
        chk("sw_mdr_kept", MDR, 32'hDEAD_BEEF);
        chk("no_err_yet", Error, 0);

        // Timeout: 15 WAIT cycles without ready
        MemRead = 1; IRWrite = 1; IorD = 1; ALUOut = 32'h108;
        @(posedge clk); @(negedge clk);
        for (int i = 1; i <= 15; i++) begin
            chk("to_req_held", mem_req, 1);
            @(posedge clk); @(negedge clk);
        end
        chk("to_req_drop", mem_req, 0);
        chk("to_err", Error, 1);
        chk("to_stall_low", Stall, 0);
        chk("to_ir", Instruction, 32'h0109_4020);
        chk("to_mdr", MDR, 32'hDEAD_BEEF);
        MemRead = 0; IRWrite = 0;
        mem_ready = 1; mem_rdata = 32'hBAD0_BAD0;
        @(posedge clk); @(negedge clk);
        mem_ready = 0;
        chk("late_rdy_mdr", MDR, 32'hDEAD_BEEF);
        chk("late_rdy_ir", Instruction, 32'h0109_4020);
        chk("late_rdy_req", mem_req, 0);

        // Reset in the middle of WAIT
        MemWrite = 1; IorD = 1; ALUOut = 32'h10C; WriteData = 32'hCAFE_F00D;
        @(posedge clk); @(negedge clk);
        @(posedge clk); @(negedge clk);
        chk("pre_rst_req", mem_req, 1);
        MemWrite = 0;
        mem_ready = 1; mem_rdata = 32'h1111_2222;
        do_reset();
        mem_ready = 0;
        check_idle_outputs("rst_wait");

        // Misaligned load (Error) then back-to-back sw / lw
        do_access(1, 0, 0, 1, 32'h0, 32'h102, 32'h0, 2, 32'hA5A5_0001);
        chk("misalign_err", Error, 1);
        do_access(0, 1, 0, 1, 32'h0, 32'h200, 32'h0BAD_CAFE, 0, 32'h0);
        do_access(1, 0, 1, 1, 32'h0, 32'h204, 32'h0, 4, 32'h8C01_0004);
`ifdef MEM_PERF_CNT_EN
        chk("perf_access", access_count, 3);
        chk("perf_wait", wait_cycles, 6);
        chk("perf_model", access_count, exp_acc);
`endif

        // Read+write together: issued as a write, Error set
        do_reset();
        MemRead = 1; MemWrite = 1; IorD = 1; ALUOut = 32'h300; WriteData = 32'h55;
        @(posedge clk); @(negedge clk);
        chk("both_we", mem_we, 1);
        chk("both_err", Error, 1);
        chk("both_wdata", mem_wdata, 32'h55);
        mem_ready = 1; mem_rdata = 32'h77;
        @(posedge clk); @(negedge clk);
        mem_ready = 0; MemRead = 0; MemWrite = 0;
        chk("both_mdr", MDR, 0);
        chk("both_req", mem_req, 0);

        // Spurious ready while idle
        mem_ready = 1; mem_rdata = 32'h9999_9999;
        @(posedge clk); @(negedge clk);
        mem_ready = 0;
        chk("idle_rdy_mdr", MDR, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
        $finish;
    end

endmodule
